// File: rtl/grant_hold_ctrl.sv
// Fixed-priority arbiter with bounded grant hold: an owner keeps the grant
// until it releases or has held for MAX_HOLD cycles, then sits out one round.
module grant_hold_ctrl #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [0:N-1]         req,
  output logic [0:N-1]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 expired
);

  localparam int ID_W  = $clog2(N);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [0:N-1]     mask, mask_nxt;
  logic [0:N-1]     grant_nxt;
  logic [ID_W-1:0]  id_nxt;
  logic             valid_nxt;
  logic             expired_nxt;

  logic [0:N-1]     cand;
  logic             win_vld;
  logic [ID_W-1:0]  win_id;

  function automatic logic [0:N-1] onehot(input logic [ID_W-1:0] id);
    logic [0:N-1] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Lowest masked index wins; scanning downward leaves the smallest index last.
  always_comb begin
    cand    = req & ~mask;
    win_vld = |cand;
    win_id  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) win_id = ID_W'(i);
    end
  end

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    mask_nxt    = mask;
    grant_nxt   = '0;
    id_nxt      = '0;
    valid_nxt   = 1'b0;
    expired_nxt = 1'b0;
    case (state)
      IDLE, GAP: begin
        mask_nxt = '0;
        if (win_vld) begin
          state_nxt = GRANT;
          grant_nxt = onehot(win_id);
          id_nxt    = win_id;
          valid_nxt = 1'b1;
          count_nxt = CNT_W'(1);
        end else begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      end
      GRANT: begin
        // A release on the final cycle counts as a release, not an expiry.
        if (!req[grant_id]) begin
          state_nxt = GAP;
          count_nxt = '0;
          mask_nxt  = '0;
        end else if (count == CNT_W'(MAX_HOLD)) begin
          state_nxt   = GAP;
          count_nxt   = '0;
          mask_nxt    = onehot(grant_id);
          expired_nxt = 1'b1;
        end else begin
          grant_nxt = grant;
          id_nxt    = grant_id;
          valid_nxt = 1'b1;
          count_nxt = count + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
        mask_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      mask        <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      expired     <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      mask        <= mask_nxt;
      grant       <= grant_nxt;
      grant_id    <= id_nxt;
      grant_valid <= valid_nxt;
      expired     <= expired_nxt;
    end
  end

endmodule

// File: tb/tb_grant_hold_ctrl.sv
// Scoreboard bench for grant_hold_ctrl: stimulus pushes the model's expected
// outputs per clock edge, a monitor pops and compares one cycle at a time.
module tb_grant_hold_ctrl;

  localparam int N    = 4;
  localparam int MAXH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [0:N-1] req = '1;
  logic [0:N-1] grant;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic         expired;

  grant_hold_ctrl #(.N(N), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .grant_valid(grant_valid), .grant_id(grant_id), .expired(expired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:N-1] g;
    logic         v;
    logic [1:0]   id;
    logic         e;
  } obs_t;

  obs_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference: who owns the bus, for how long, and who must sit out next round.
  int m_owner = -1;
  int m_held  = 0;
  int m_excl  = -1;
  bit m_gap   = 1'b0;
  bit m_exp   = 1'b0;

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_excl = -1; m_gap = 1'b0; m_exp = 1'b0;
  endtask

  function automatic int pick(input logic [0:N-1] r, input int excl);
    for (int i = 0; i < N; i++) if (r[i] && i != excl) return i;
    return -1;
  endfunction

  task automatic model_step(input logic [0:N-1] r);
    int   w;
    obs_t o;
    m_exp = 1'b0;
    if (m_owner >= 0) begin
      if (r[m_owner] && m_held < MAXH) m_held++;
      else begin
        m_exp   = r[m_owner];
        m_excl  = m_exp ? m_owner : -1;
        m_owner = -1;
        m_gap   = 1'b1;
      end
    end else begin
      w      = pick(r, m_gap ? m_excl : -1);
      m_gap  = 1'b0;
      m_excl = -1;
      if (w >= 0) begin m_owner = w; m_held = 1; end
    end
    o    = '0;
    if (m_owner >= 0) begin
      o.g[m_owner] = 1'b1;
      o.v          = 1'b1;
      o.id         = 2'(m_owner);
    end
    o.e = m_exp;
    sb.push_back(o);
  endtask

  task automatic step(input logic r_rst, input logic [0:N-1] r);
    @(negedge clk);
    rst = r_rst;
    req = r;
    if (r_rst) begin
      model_reset();
      sb.push_back(obs_t'(0));
    end else begin
      model_step(r);
    end
  endtask

  task automatic hold(input logic [0:N-1] r, input int n);
    repeat (n) step(1'b0, r);
  endtask

  // Reset pulse wholly between clock edges; outputs must clear before any edge.
  task automatic async_pulse(input logic [0:N-1] r);
    @(negedge clk);
    req = r;
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({grant, grant_valid, grant_id, expired} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got grant=%b valid=%b id=%0d expired=%b, need all zero",
               grant, grant_valid, grant_id, expired);
    end
    #1 rst = 1'b0;
    model_reset();
    model_step(r);
  endtask

  always @(posedge clk) begin
    obs_t e, a;
    #1;
    cyc++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      a = {grant, grant_valid, grant_id, expired};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle %0d: got grant=%b valid=%b id=%0d expired=%b, need grant=%b valid=%b id=%0d expired=%b",
                 cyc, a.g, a.v, a.id, a.e, e.g, e.v, e.id, e.e);
      end
    end
  end

  initial begin
    logic [0:N-1] r;
    int           n, sel, k;

    repeat (3) step(1'b1, 4'b1111);
    hold(4'b0000, 1);
    hold(4'b0110, 4);
    hold(4'b0000, 2);
    hold(4'b1000, 12);
    hold(4'b0000, 2);
    hold(4'b1100, 20);
    hold(4'b0000, 2);
    hold(4'b0010, 1);
    hold(4'b1010, 2);
    hold(4'b1000, 3);
    hold(4'b0000, 2);
    hold(4'b0100, 2);
    async_pulse(4'b0000);
    hold(4'b0000, 3);

    for (int i = 0; i < 150; i++) begin
      r   = N'($urandom);
      n   = $urandom_range(1, 6);
      sel = $urandom_range(0, 19);
      if (sel == 0)      async_pulse(r);
      else if (sel == 1) step(1'b1, r);
      else               hold(r, n);
    end
    hold(4'b0000, 2);

    k = 0;
    while (sb.size() != 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries, need 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/grant_hold_ctrl.md
GRANT_HOLD_CTRL -- requirements
Module: grant_hold_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of requesters (N >= 2).
REQ-002 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum consecutive grant cycles per ownership (MAX_HOLD >= 1).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports as in REQ-004 and REQ-005.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port req, input, [0:N-1]: request vector, where index 0 is the highest priority.
REQ-007 The block SHALL have port grant, output, [0:N-1]: registered grant vector, one-hot or zero.
REQ-008 The block SHALL have port grant_valid, output, 1 bit: OR of grant.
REQ-009 The block SHALL have port grant_id, output, $clog2(N) bits: index of the asserted grant bit, 0 when grant_valid=0.
REQ-010 The block SHALL have port expired, output, 1 bit: one-cycle pulse when an ownership ends by reaching MAX_HOLD.

Function
REQ-011 All outputs SHALL be registered, and grant SHALL never have more than one bit set.
REQ-012 The block SHALL implement a three-state FSM with states IDLE, GRANT and GAP.
REQ-013 Arbitration SHALL be fixed priority: the winner is the lowest index i with (req[i] & ~mask[i]) = 1.
REQ-014 In IDLE, grant SHALL be zero; if any req bit is set at a clock edge, the next state SHALL be GRANT, with grant = one-hot of the winner, count = 1 and mask cleared.
REQ-015 Grant latency SHALL be one cycle: a request sampled in IDLE at edge t is granted in the cycle starting at edge t.
REQ-016 In GRANT, the owner SHALL keep the grant while req[owner]=1 and count < MAX_HOLD, and count SHALL increment each cycle the grant is held.
REQ-017 In GRANT with req[owner]=0 at an edge, the next state SHALL be GAP, with grant cleared, mask = 0 and expired = 0.
REQ-018 In GRANT with req[owner]=1 and count = MAX_HOLD at an edge, the next state SHALL be GAP, with grant cleared, mask = one-hot(owner) and expired = 1 for that GAP cycle only.
REQ-019 When req[owner] drops in the same cycle that count = MAX_HOLD, the event SHALL be treated as a release: expired = 0 and mask = 0.
REQ-020 No preemption SHALL occur: a higher-priority request arriving during GRANT SHALL NOT change grant until the ownership ends.
REQ-021 In GAP, grant SHALL be zero for exactly one cycle, and the block SHALL then arbitrate on masked req.
REQ-022 From GAP, a nonzero masked req SHALL lead to GRANT with the winner, count = 1 and mask cleared.
REQ-023 From GAP, a zero masked req SHALL lead to IDLE with mask cleared, so a lone expired owner is re-granted after two dead cycles.
REQ-024 A grant SHALL be asserted for at most MAX_HOLD consecutive cycles, and consecutive ownerships SHALL be separated by at least one zero-grant cycle.
REQ-025 With MAX_HOLD = 1, each ownership SHALL last one cycle, followed by GAP.
REQ-026 Requests from non-owners SHALL be ignored outside arbitration points (IDLE, GAP) and SHALL NOT be latched.
REQ-027 The count register SHALL be wide enough to hold MAX_HOLD without wrap-around.

Reset
REQ-028 While rst=1, the block SHALL immediately, without a clock edge, set state = IDLE, grant = 0, grant_valid = 0, grant_id = 0, expired = 0, count = 0 and mask = 0.
REQ-029 Reset asserted mid-GRANT or mid-GAP SHALL drop the grant immediately and discard mask and count.
REQ-030 After rst deasserts, the first arbitration SHALL occur at the first clock edge in IDLE.

Verification (N=4, MAX_HOLD=4; vectors written as req[0]..req[3])
REQ-031 The bench SHALL check reset: rst=1 with req=1111 -> grant=0000, grant_valid=0, grant_id=0 and expired=0 throughout.
REQ-032 The bench SHALL check priority and latency: in IDLE, req=0110 at edge t -> grant=0100, grant_id=1 from t, and held while req[1]=1.
REQ-033 The bench SHALL check expiry: req=1000 held for 12 cycles -> grant=1000 for 4 cycles, then 0000 for 2 cycles (expired=1 in the first), then 1000 again.
REQ-034 The bench SHALL check fairness: req=1100 held -> grant 1000 x4, gap (expired=1), 0100 x4, gap (expired=1), 1000 x4, repeating.
REQ-035 The bench SHALL check no preemption: owner index 2 granted, req[0] rises -> grant stays 0010 until req[2] drops, then one 0000 cycle with expired=0, then 1000.
REQ-036 The bench SHALL check asynchronous reset: rst pulsed between clock edges during grant=0100 -> grant=0000 before the next edge, and after release with req=0000 the block stays in IDLE.
